apb3_cmd_master: RTL and testbench



---
 rtl/apb3_pkg.sv | 39 +++
 rtl/apb3_timeout_ctr.sv | 29 ++
 rtl/apb3_cmd_master.sv | 129 ++++++++++++
 tb/tb_apb3_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 command master.
// State encoding, bus widths and the response bundle.
package apb3_pkg;

  localparam int APB_DWIDTH = 32;
  localparam int TMO_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DWIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  localparam rsp_t RSP_TMO = '{
    rdata:   '0,
    err:     1'b1,
    timeout: 1'b1
  };

  function automatic rsp_t mk_rsp(
    input logic                  is_write,
    input logic [APB_DWIDTH-1:0] prdata,
    input logic                  pslverr
  );
    rsp_t r;
    r.rdata   = is_write ? '0 : prdata;
    r.err     = pslverr;
    r.timeout = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/apb3_timeout_ctr.sv
// ACCESS-phase wait counter for the APB3 command master.
// Flags expiry on the last permitted wait cycle; limit 0 disables.
module apb3_timeout_ctr
  import apb3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TMO_WIDTH-1:0] limit,
  output logic                 expired
);

  logic [TMO_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (limit != '0) &&
                   (cnt == limit - {{(TMO_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/apb3_cmd_master.sv
// APB3 master driven by a valid/ready command channel.
// One transfer in flight; response held until RSP_READY.
module apb3_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int APB_DWIDTH     = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [APB_DWIDTH-1:0] CMD_ADDR,
  input  logic [APB_DWIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [APB_DWIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic [APB_DWIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  import apb3_pkg::*;

  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT =
    TMO_WIDTH'(TIMEOUT_CYCLES);

  apb_state_e            state;
  logic                  cmd_ready;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DWIDTH-1:0] paddr;
  logic [APB_DWIDTH-1:0] pwdata;
  logic                  rsp_valid;
  rsp_t                  rsp;

  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;

  // Counter restarts in SETUP so it reads 0 on the first ACCESS cycle.
  assign tmo_clear = (state == SETUP);
  assign tmo_en    = (state == ACCESS) && !PREADY;

  apb3_timeout_ctr u_tmo (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CMD_VALID && cmd_ready) begin
            paddr     <= CMD_ADDR;
            pwdata    <= CMD_WDATA;
            pwrite    <= CMD_WRITE;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY beats the timeout when both land on one cycle.
          if (PREADY) begin
            rsp       <= mk_rsp(pwrite, PRDATA, PSLVERR);
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_expired) begin
            rsp       <= RSP_TMO;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign CMD_READY   = cmd_ready;
  assign PSEL        = psel;
  assign PENABLE     = penable;
  assign PWRITE      = pwrite;
  assign PADDR       = paddr;
  assign PWDATA      = pwdata;
  assign RSP_VALID   = rsp_valid;
  assign RSP_RDATA   = rsp.rdata;
  assign RSP_ERR     = rsp.err;
  assign RSP_TIMEOUT = rsp.timeout;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Scoreboard bench for apb3_cmd_master.
// Main thread plays the APB slave; a monitor checks responses.
module tb_apb3_cmd_master;

  import apb3_pkg::*;

  localparam int TMO = 8;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb3_cmd_master #(
    .TIMEOUT_CYCLES (TMO),
    .APB_DWIDTH     (32)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_WRITE   (CMD_WRITE),
    .CMD_ADDR    (CMD_ADDR),
    .CMD_WDATA   (CMD_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rsp_t r(input logic [31:0] d,
                             input logic e,
                             input logic t);
    rsp_t x;
    x.rdata   = d;
    x.err     = e;
    x.timeout = t;
    return x;
  endfunction

  // Response monitor: compares on each handshake.
  always @(negedge PCLK) begin
    rsp_t e;
    if (!PRESET && RSP_VALID && RSP_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h, expected none",
                 RSP_RDATA);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", RSP_RDATA, e.rdata);
        chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
        chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.timeout));
      end
    end
  end

  task automatic issue(input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d);
    bit ok;
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (CMD_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: got CMD_READY 0, expected 1");
    end
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_ADDR  = 32'hFFFF_FFFF;
    CMD_WDATA = 32'h5555_5555;
    CMD_WRITE = ~w;
  endtask

  // waits = ACCESS cycles with PREADY low before the ready cycle.
  task automatic xfer(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input int waits,
                      input logic [31:0] rd,
                      input logic err_in,
                      input int exp_access,
                      input rsp_t exp);
    int  n;
    int  lat;
    bit  seen;
    exp_q.push_back(exp);
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'hBAD0_0000;
    issue(w, a, d);
    n    = 0;
    seen = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge PCLK);
      if (RSP_VALID) begin
        seen = 1'b1;
        break;
      end
      if (lat == 1) begin
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
      end else if (PSEL && PENABLE) begin
        n++;
        if (n == 1) begin
          chk("paddr", PADDR, a);
          chk("pwrite", 32'(PWRITE), 32'(w));
          chk("pwdata", PWDATA, d);
        end
        PREADY  = (n > waits);
        PRDATA  = (n > waits) ? rd : (32'hBAD0_0000 | n);
        PSLVERR = (n > waits) ? err_in : 1'b1;
      end
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("access_cycles", n, exp_access);
    chk("latency", lat, exp_access + 2);
    chk("resp_psel", 32'(PSEL), 32'd0);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with a command pending; it must not be taken.
    PRESET    = 1'b1;
    CMD_VALID = 1'b1;
    CMD_ADDR  = 32'h1111_0000;
    CMD_WDATA = 32'h2222_0000;
    CMD_WRITE = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    @(posedge PCLK);
    #1;
    PRESET    = 1'b0;
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_rsp_tmo", 32'(RSP_TIMEOUT), 32'd0);
    @(negedge PCLK);
    chk("rst_no_accept", 32'(PSEL), 32'd0);

    // Write, zero wait.
    xfer(1'b1, 32'h7000_0004, 32'hDEAD_BEEF, 0, 32'h0BAD_0BAD,
         1'b0, 1, r(32'h0, 1'b0, 1'b0));
    // Read, 5 wait states.
    xfer(1'b0, 32'h7000_0010, 32'hAAAA_0001, 5, 32'h1234_5678,
         1'b0, 6, r(32'h1234_5678, 1'b0, 1'b0));
    // Slave error on read.
    xfer(1'b0, 32'h7000_0020, 32'h0, 0, 32'h0BAD_F00D,
         1'b1, 1, r(32'h0BAD_F00D, 1'b1, 1'b0));
    // Slave error on write: rdata forced to zero.
    xfer(1'b1, 32'h7000_0024, 32'h0000_00FF, 2, 32'hFFFF_FFFF,
         1'b1, 3, r(32'h0, 1'b1, 1'b0));
    // Timeout: PREADY never comes.
    xfer(1'b0, 32'h7000_0030, 32'h0, 1000, 32'h0,
         1'b0, TMO, r(32'h0, 1'b1, 1'b1));
    // PREADY on the 8th cycle wins over the timeout.
    xfer(1'b0, 32'h7000_0034, 32'h0, TMO - 1, 32'hCAFE_0008,
         1'b0, TMO, r(32'hCAFE_0008, 1'b0, 1'b0));
    // One cycle before the limit.
    xfer(1'b0, 32'h7000_0038, 32'h0, TMO - 2, 32'hCAFE_0007,
         1'b0, TMO - 1, r(32'hCAFE_0007, 1'b0, 1'b0));

    // Backpressure: response held, next command stalled.
    @(posedge PCLK);
    #1;
    RSP_READY = 1'b0;
    xfer(1'b0, 32'h7000_0040, 32'h0, 1, 32'h5A5A_A5A5,
         1'b0, 2, r(32'h5A5A_A5A5, 1'b0, 1'b0));
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 32'h7000_0044;
    CMD_WDATA = 32'h0000_0044;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      chk("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp_rsp_rdata", RSP_RDATA, 32'h5A5A_A5A5);
      chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
      chk("bp_psel", 32'(PSEL), 32'd0);
    end
    @(posedge PCLK);
    #1;
    RSP_READY = 1'b1;
    xfer(1'b1, 32'h7000_0044, 32'h0000_0044, 0, 32'h0,
         1'b0, 1, r(32'h0, 1'b0, 1'b0));

    // Reset during the 3rd ACCESS wait cycle.
    PREADY = 1'b0;
    issue(1'b0, 32'h7000_0050, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) n++;
      if (n == 3) break;
    end
    chk("mid_rst_access", n, 3);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_cmd_ready", 32'(CMD_READY), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      chk("mid_rst_no_rsp", 32'(RSP_VALID), 32'd0);
    end

    // Recovery transfer.
    xfer(1'b0, 32'h7000_0060, 32'h0, 1, 32'h0600_0060,
         1'b0, 2, r(32'h0600_0060, 1'b0, 1'b0));
    repeat (3) @(negedge PCLK);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
